fft_sdf_r2: RTL and testbench

Parametrised radix-2 single-path delay-feedback (SDF) decimation-in-frequency FFT. It streams one complex sample per accepted cycle and emits one complex bin per accepted cycle in bit-reversed order, with a bin index and a frame-end marker. It is the generalised successor of the fixed 8-point, 16-bit streaming FFT processor in the FFT datapath. It adds:
- configurable point count and widths;
- a synchronous reset;
- a valid-gated (stallable) pipeline;
- exact Q-format twiddles with rounding and saturation.

---
 rtl/fft_sdf_r2_if.sv | 24 ++
 rtl/fft_sdf_r2.sv | 168 ++++++++++++++++
 tb/tb_fft_sdf_r2.sv | 211 +++++++++++++++++++++
 3 files changed

// File: rtl/fft_sdf_r2_if.sv
// rtl/fft_sdf_r2_if.sv - sample-in / bin-out streaming bus of the radix-2 SDF FFT
interface fft_sdf_r2_if #(
  parameter int N = 16,
  parameter int W = 16
);
  logic                 in_valid;
  logic signed [W-1:0]  xr;
  logic signed [W-1:0]  xi;
  logic                 out_valid;
  logic signed [W-1:0]  Xr;
  logic signed [W-1:0]  Xi;
  logic [$clog2(N)-1:0] out_index;
  logic                 out_last;

  modport master (
    output in_valid, xr, xi,
    input  out_valid, Xr, Xi, out_index, out_last
  );

  modport slave (
    input  in_valid, xr, xi,
    output out_valid, Xr, Xi, out_index, out_last
  );
endinterface

// File: rtl/fft_sdf_r2.sv
// rtl/fft_sdf_r2.sv - stallable radix-2 single-path delay-feedback DIF FFT, bit-reversed output
module fft_sdf_r2 #(
  parameter int N  = 16,
  parameter int W  = 16,
  parameter int TW = 16
) (
  input  logic        c,
  input  logic        rst,
  fft_sdf_r2_if.slave bus
);
  localparam int S  = $clog2(N);
  localparam int L  = N - 1 + S;
  localparam int PW = $clog2(L + 1);
  localparam int MW = W + TW;
  localparam logic signed [MW-1:0] RND = MW'(1) <<< (TW - 3);

  // Twiddle value in Q1.(TW-2), evaluated at elaboration with a plain power series
  function automatic int tw_val(input int k, input bit want_cos);
    real a, t, re, im, v;
    a  = 6.283185307179586 * real'(k) / real'(N);
    re = 1.0;
    im = 0.0;
    t  = 1.0;
    for (int i = 1; i < 40; i++) begin
      t = t * a / real'(i);
      case (i % 4)
        1:       im = im + t;
        2:       re = re - t;
        3:       im = im - t;
        default: re = re + t;
      endcase
    end
    v = (want_cos ? re : im) * real'(longint'(1) << (TW - 2));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  function automatic logic [S-1:0] bitrev(input logic [S-1:0] v);
    logic [S-1:0] r;
    for (int i = 0; i < S; i++) r[i] = v[S-1-i];
    return r;
  endfunction

  function automatic logic signed [W-1:0] sat(input logic signed [MW-1:0] v);
    if (v[MW-1:W-1] == {(TW+1){v[MW-1]}}) return v[W-1:0];
    return v[MW-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
  endfunction

  logic                     adv;
  logic [S-1:0]             cnt;
  logic [S-1:0]             oc;
  logic [PW-1:0]            prime;
  logic [N/2-1:0][TW-1:0]   cos_tab;
  logic [N/2-1:0][TW-1:0]   sin_tab;
  logic [S:0][W-1:0]        st_r;
  logic [S:0][W-1:0]        st_i;

  assign adv     = bus.in_valid;
  assign st_r[0] = bus.xr;
  assign st_i[0] = bus.xi;

  for (genvar k = 0; k < N/2; k++) begin : g_rom
    localparam logic [TW-1:0] CV = TW'(tw_val(k, 1'b1));
    localparam logic [TW-1:0] SV = TW'(tw_val(k, 1'b0));
    assign cos_tab[k] = CV;
    assign sin_tab[k] = SV;
  end

  for (genvar g = 0; g < S; g++) begin : g_stage
    localparam int D  = N >> (g + 1);
    localparam int LD = S - 1 - g;
    // Advance at which the first sample of frame 0 reaches this stage
    localparam int TS = N - (N >> g) + g;

    logic [S-1:0]         loc;
    logic [S-2:0]         nidx;
    logic                 bf;
    logic signed [W-1:0]  ir, ii, hr, hi, cw, sw;
    logic signed [W-1:0]  push_r, push_i, fwd_r, fwd_i, q_r, q_i;
    logic signed [W:0]    ar, ai, dr_s, di_s;
    logic signed [MW-1:0] mr, mi;
    logic [W-1:0]         dl_r [D];
    logic [W-1:0]         dl_i [D];

    assign loc  = cnt - S'(TS);
    assign bf   = loc[LD];
    assign nidx = (S-1)'((loc & S'(D - 1)) << g);
    assign ir   = st_r[g];
    assign ii   = st_i[g];
    assign hr   = dl_r[D-1];
    assign hi   = dl_i[D-1];
    assign cw   = cos_tab[nidx];
    assign sw   = sin_tab[nidx];
    assign ar   = {hr[W-1], hr} + {ir[W-1], ir};
    assign ai   = {hi[W-1], hi} + {ii[W-1], ii};
    assign dr_s = {hr[W-1], hr} - {ir[W-1], ir};
    assign di_s = {hi[W-1], hi} - {ii[W-1], ii};
    // (hr + j*hi) * (cos - j*sin)
    assign mr   = MW'(hr) * MW'(cw) + MW'(hi) * MW'(sw);
    assign mi   = MW'(hi) * MW'(cw) - MW'(hr) * MW'(sw);

    always_comb begin
      push_r = ir;
      push_i = ii;
      fwd_r  = hr;
      fwd_i  = hi;
      if (bf) begin
        fwd_r  = W'(ar >>> 1);
        fwd_i  = W'(ai >>> 1);
        push_r = W'(dr_s >>> 1);
        push_i = W'(di_s >>> 1);
      end else if (nidx != '0) begin
        fwd_r = sat((mr + RND) >>> (TW - 2));
        fwd_i = sat((mi + RND) >>> (TW - 2));
      end
    end

    always_ff @(posedge c) begin
      if (rst) begin
        for (int i = 0; i < D; i++) begin
          dl_r[i] <= '0;
          dl_i[i] <= '0;
        end
        q_r <= '0;
        q_i <= '0;
      end else if (adv) begin
        dl_r[0] <= push_r;
        dl_i[0] <= push_i;
        for (int i = 1; i < D; i++) begin
          dl_r[i] <= dl_r[i-1];
          dl_i[i] <= dl_i[i-1];
        end
        q_r <= fwd_r;
        q_i <= fwd_i;
      end
    end

    assign st_r[g+1] = q_r;
    assign st_i[g+1] = q_i;
  end

  always_ff @(posedge c) begin
    if (rst) begin
      cnt           <= '0;
      prime         <= '0;
      oc            <= '0;
      bus.out_valid <= 1'b0;
      bus.Xr        <= '0;
      bus.Xi        <= '0;
      bus.out_index <= '0;
      bus.out_last  <= 1'b0;
    end else begin
      bus.out_valid <= adv && (prime == PW'(L));
      if (adv) begin
        cnt    <= cnt + 1'b1;
        bus.Xr <= st_r[S];
        bus.Xi <= st_i[S];
        if (prime == PW'(L)) begin
          bus.out_index <= bitrev(oc);
          bus.out_last  <= (oc == S'(N - 1));
          oc            <= oc + 1'b1;
        end else begin
          prime <= prime + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_fft_sdf_r2.sv
// tb/tb_fft_sdf_r2.sv - directed self-checking bench for fft_sdf_r2 (N=16 and N=64)
module tb_fft_sdf_r2;
  logic c = 1'b0;
  logic rst = 1'b1;
  always #5 c = ~c;

  fft_sdf_r2_if #(.N(16), .W(16)) f16 ();
  fft_sdf_r2_if #(.N(64), .W(16)) f64 ();

  fft_sdf_r2 #(.N(16), .W(16), .TW(16)) dut16 (.c(c), .rst(rst), .bus(f16.slave));
  fft_sdf_r2 #(.N(64), .W(16), .TW(16)) dut64 (.c(c), .rst(rst), .bus(f64.slave));

  int total = 0;
  int bad = 0;
  int adv = 0;
  int first_adv = -1;
  int viol = 0;
  int cap_r[$], cap_i[$], cap_x[$], cap_l[$];
  int imp_r[$], imp_i[$], imp_x[$];
  int ref_r[$], ref_i[$], ref_x[$];
  int bro16 [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};

  function automatic int brev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic int tone_val(input int n, input int npts, input bit im);
    real a, v;
    a = 6.283185307179586 * 3.0 * real'(n) / real'(npts);
    v = 8192.0 * (im ? $sin(a) : $cos(a));
    if (v >= 0.0) return $rtoi(v + 0.5);
    return -$rtoi(0.5 - v);
  endfunction

  task automatic check(input string tag, input int obs, input int exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_near(input string tag, input int obs, input int exp, input int tol);
    bit ok;
    ok = (obs >= exp - tol) && (obs <= exp + tol);
    total++;
    assert (ok === 1'b1) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d+-%0d", tag, obs, exp, tol);
    end
  endtask

  task automatic clear_caps();
    cap_r.delete(); cap_i.delete(); cap_x.delete(); cap_l.delete();
    adv = 0;
    first_adv = -1;
  endtask

  task automatic tick(input bit big, input bit v, input int r, input int i);
    bit ov;
    if (big) begin
      f64.in_valid = v; f64.xr = 16'(r); f64.xi = 16'(i); f16.in_valid = 1'b0;
    end else begin
      f16.in_valid = v; f16.xr = 16'(r); f16.xi = 16'(i); f64.in_valid = 1'b0;
    end
    @(posedge c);
    #1;
    ov = big ? f64.out_valid : f16.out_valid;
    if (ov) begin
      if (!v) viol++;
      if (first_adv < 0) first_adv = adv;
      cap_r.push_back(big ? int'(f64.Xr) : int'(f16.Xr));
      cap_i.push_back(big ? int'(f64.Xi) : int'(f16.Xi));
      cap_x.push_back(big ? int'(f64.out_index) : int'(f16.out_index));
      cap_l.push_back(big ? int'(f64.out_last) : int'(f16.out_last));
    end
    if (v && !rst) adv++;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    f16.in_valid = 1'b0;
    f64.in_valid = 1'b0;
    repeat (2) @(posedge c);
    #1;
    rst = 1'b0;
    clear_caps();
  endtask

  task automatic run_until(input bit big, input int want, input int limit);
    int g = 0;
    while (cap_r.size() < want && g < limit) begin
      tick(big, 1'b1, 0, 0);
      g++;
    end
    check("capture_count_reached", int'(cap_r.size() >= want), 1);
  endtask

  task automatic check_tone(input string tag, input int npts, input int bits);
    for (int k = 0; k < npts; k++) begin
      check($sformatf("%s_index_%0d", tag, k), cap_x[k], brev(k, bits));
      if (cap_x[k] == 3) begin
        check_near($sformatf("%s_bin3_re", tag), cap_r[k], 8192, 4);
        check_near($sformatf("%s_bin3_im", tag), cap_i[k], 0, 4);
      end else begin
        check_near($sformatf("%s_bin%0d_re", tag, cap_x[k]), cap_r[k], 0, 4);
        check_near($sformatf("%s_bin%0d_im", tag, cap_x[k]), cap_i[k], 0, 4);
      end
    end
  endtask

  initial begin
    f16.in_valid = 1'b0; f16.xr = '0; f16.xi = '0;
    f64.in_valid = 1'b0; f64.xr = '0; f64.xi = '0;

    // reset state
    rst = 1'b1;
    repeat (3) @(posedge c);
    #1;
    check("rst_out_valid", int'(f16.out_valid), 0);
    check("rst_Xr", int'(f16.Xr), 0);
    check("rst_Xi", int'(f16.Xi), 0);
    check("rst_out_index", int'(f16.out_index), 0);
    check("rst_out_last", int'(f16.out_last), 0);
    rst = 1'b0;
    clear_caps();
    for (int n = 0; n < 20; n++) begin
      tick(1'b0, 1'b0, 0, 0);
      check("idle_out_valid", int'(f16.out_valid), 0);
    end

    // impulse
    for (int n = 0; n < 16; n++) tick(1'b0, 1'b1, (n == 0) ? 16384 : 0, 0);
    run_until(1'b0, 16, 100);
    check("impulse_first_valid_adv", first_adv, 19);
    for (int k = 0; k < 16; k++) begin
      check_near("impulse_re", cap_r[k], 1024, 1);
      check_near("impulse_im", cap_i[k], 0, 1);
      check("impulse_index", cap_x[k], bro16[k]);
      check("impulse_last", cap_l[k], (k == 15) ? 1 : 0);
    end
    imp_r = cap_r; imp_i = cap_i; imp_x = cap_x;

    // DC full scale, frames 0 and 1
    do_reset();
    for (int n = 0; n < 48; n++) tick(1'b0, 1'b1, -32768, 0);
    run_until(1'b0, 32, 100);
    for (int k = 0; k < 32; k++) begin
      if (cap_x[k] == 0) check("dc_bin0_re", cap_r[k], -32768);
      else check_near("dc_bin_re", cap_r[k], 0, 1);
      check_near("dc_bin_im", cap_i[k], 0, 1);
    end

    // tone at bin 3, N=16
    do_reset();
    for (int n = 0; n < 40; n++)
      tick(1'b0, 1'b1, (n < 32) ? tone_val(n, 16, 1'b0) : 0, (n < 32) ? tone_val(n, 16, 1'b1) : 0);
    run_until(1'b0, 16, 100);
    check_tone("tone16", 16, 4);
    ref_r = cap_r; ref_i = cap_i; ref_x = cap_x;

    // tone at bin 3, N=64
    do_reset();
    for (int n = 0; n < 136; n++)
      tick(1'b1, 1'b1, (n < 128) ? tone_val(n, 64, 1'b0) : 0, (n < 128) ? tone_val(n, 64, 1'b1) : 0);
    run_until(1'b1, 64, 200);
    check_tone("tone64", 64, 6);

    // stalled tone, N=16
    do_reset();
    viol = 0;
    for (int n = 0; n < 40; n++) begin
      for (int g = 0; g < 8 && $urandom_range(0, 1) == 1; g++) tick(1'b0, 1'b0, 0, 0);
      tick(1'b0, 1'b1, (n < 32) ? tone_val(n, 16, 1'b0) : 0, (n < 32) ? tone_val(n, 16, 1'b1) : 0);
    end
    for (int g = 0; g < 200 && cap_r.size() < 16; g++) begin
      if ($urandom_range(0, 1) == 1) tick(1'b0, 1'b0, 0, 0);
      else tick(1'b0, 1'b1, 0, 0);
    end
    check("stall_capture_count_reached", int'(cap_r.size() >= 16), 1);
    check("stall_valid_after_gap", viol, 0);
    for (int k = 0; k < 16; k++) begin
      check("stall_re", cap_r[k], ref_r[k]);
      check("stall_im", cap_i[k], ref_i[k]);
      check("stall_index", cap_x[k], ref_x[k]);
    end

    // reset in the middle of frame 1, then resend the impulse
    do_reset();
    for (int n = 0; n < 16; n++) tick(1'b0, 1'b1, (n == 0) ? 16384 : 0, 0);
    for (int n = 0; n < 7; n++) tick(1'b0, 1'b1, 0, 0);
    rst = 1'b1;
    tick(1'b0, 1'b1, 16384, 0);
    rst = 1'b0;
    check("midrst_out_valid", int'(f16.out_valid), 0);
    clear_caps();
    for (int n = 0; n < 16; n++) tick(1'b0, 1'b1, (n == 0) ? 16384 : 0, 0);
    run_until(1'b0, 16, 100);
    check("midrst_first_valid_adv", first_adv, 19);
    for (int k = 0; k < 16; k++) begin
      check("midrst_re", cap_r[k], imp_r[k]);
      check("midrst_im", cap_i[k], imp_i[k]);
      check("midrst_index", cap_x[k], imp_x[k]);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
